hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage core. Watches IF/ID, ID/EX and EX/MEM state and drives the enables and bubble/flush strobes of the PC, IF/ID, ID/EX and EX/MEM registers. It resolves three conditions:
- load-use hazards, with a one-cycle stall;
- taken branches resolved in MEM, with a three-stage squash;
- data-memory busy, with a whole-pipeline freeze.

It optionally keeps hazard performance counters.

## Interface
Parameters:
- ZERO_REG, 5'd31, register index that never creates a dependency (XZR)
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- id_r1, id_r2  in  5 each  source register indices of the instruction in ID
- id_uses_r1, id_uses_r2  in  1 each  ID instruction reads that source
- ex_rd  in  5  destination of the instruction in EX (ID/EX rd)
- ex_mem_read  in  1  instruction in EX is a load
- ex_reg_write  in  1  instruction in EX writes the register file
- mem_take_branch  in  1  taken branch (cond, uncond or reg) resolved in MEM this cycle
- dmem_busy  in  1  data memory not ready; the MEM stage must hold
- pc_en  out  1  PC register enable
- pc_sel_branch  out  1  PC loads the branch target instead of PC+4
- if_id_en  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_en  out  1  ID/EX enable
- id_ex_bubble  out  1  ID/EX control inputs forced to 0
- ex_mem_en  out  1  EX/MEM enable
- ex_mem_bubble  out  1  EX/MEM control inputs forced to 0
- mem_wb_en  out  1  MEM/WB enable
- stall_cnt, flush_cnt, freeze_cnt  out  CNT_W each  performance counters (macro-dependent)

## Operation
- The state register takes one of three values: RUN, STALL, FREEZE.
- Combinational terms:
  - `lu_hz = ex_mem_read & ex_reg_write & (ex_rd != ZERO_REG) & ((id_uses_r1 & id_r1 == ex_rd) | (id_uses_r2 & id_r2 == ex_rd))`
  - `br = mem_take_branch`
  - `fz = dmem_busy`
- Priority is freeze > branch > load-use.
- **Freeze** (fz = 1):
  - All five enables are 0; all bubbles and flushes are 0.
  - `pc_sel_branch = br` but is not acted on, because pc_en = 0.
  - Next state is FREEZE.
- **Branch** (fz = 0, br = 1):
  - pc_en = 1 and pc_sel_branch = 1.
  - if_id_flush, id_ex_bubble and ex_mem_bubble are all 1.
  - All enables are 1.
  - Next state is RUN, even if lu_hz = 1 (the consumer is squashed).
- **Load-use** (fz = 0, br = 0, lu_hz = 1, state != STALL):
  - pc_en = 0, if_id_en = 0, id_ex_en = 1, id_ex_bubble = 1.
  - ex_mem_en = 1, mem_wb_en = 1.
  - Next state is STALL.
- **STALL state** (fz = 0, br = 0): normal flow. A second load-use stall is suppressed even if lu_hz is still asserted, so the stall lasts at most one cycle per load. Next state is RUN.
- **FREEZE state with fz = 0:** follow the RUN rules. STALL history is lost; this is safe because the load has already advanced.
- **Normal RUN:** all enables 1, all bubbles and flushes 0, pc_sel_branch 0.

## Timing
- All outputs are combinational from the current state and inputs; there is no added latency.
- A load-use hazard detected in cycle N:
  - the bubble enters ID/EX at edge N+1;
  - the consumer re-enters ID/EX at edge N+2.
- A branch in MEM at cycle N: the PC holds the target after edge N+1, and the three younger instructions are squashed at that edge.
- Reset (reset = 0, asynchronous):
  - state goes to RUN; counters go to 0;
  - while reset is low, all enables are 0, all bubbles and flushes are 1, and pc_sel_branch is 0.
- Release is synchronous to the next clk edge; RUN behaviour applies from the first edge after reset goes high.
- Reset mid-stall or mid-freeze drops the pending state with no residual stall.
- Simultaneous fz and br: freeze wins and br must be held by MEM until the freeze ends. The branch is taken in the first non-frozen cycle.

## Configuration
- The macro is HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each load-use stall cycle;
  - flush_cnt increments on each branch-squash cycle;
  - freeze_cnt increments on each freeze cycle.
  - Counters wrap modulo 2^CNT_W.
- Undefined: no counter flops; the three counter outputs are tied to 0.

## Test plan
- **Load-use:** ex_mem_read = 1, ex_reg_write = 1, ex_rd = 3, id_r1 = 3, id_uses_r1 = 1 → one cycle of pc_en = 0, if_id_en = 0, id_ex_bubble = 1; next cycle all enables are 1 with inputs held; stall_cnt = 1.
- **XZR and non-use:** ex_rd = 31 with a matching id_r1, or id_uses_r1 = 0 → no stall; all enables stay 1.
- **Branch over load-use:** mem_take_branch = 1 and lu_hz = 1 in the same cycle → pc_sel_branch = 1; if_id_flush, id_ex_bubble and ex_mem_bubble are 1; no stall; state RUN; flush_cnt = 1.
- **Freeze:** dmem_busy = 1 for 3 cycles with mem_take_branch = 1 → all enables 0 for 3 cycles, then one branch-squash cycle; freeze_cnt = 3, flush_cnt = 1.
- **Async reset:** drive reset = 0 in the STALL state between clock edges → outputs immediately show enables 0 and flushes 1; after release there is no stall cycle and counters read 0.
- **Counter wrap (CNT_W = 4, macro defined):** 17 stall cycles → stall_cnt = 1. With the macro undefined → all counter outputs read 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, MEM-resolved branch squash, dmem-busy freeze.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter logic [4:0] ZERO_REG = 5'd31,
  parameter int         CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_r1,
  input  logic [4:0]       id_r2,
  input  logic             id_uses_r1,
  input  logic             id_uses_r2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic             mem_take_branch,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             pc_sel_branch,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             ex_mem_bubble,
  output logic             mem_wb_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  typedef enum logic [1:0] {RUN, STALL, FREEZE} state_t;

  state_t state, state_nxt;
  logic   lu_hz, br, fz;
  logic   stall_ev, flush_ev, freeze_ev;

  assign lu_hz = ex_mem_read & ex_reg_write & (ex_rd != ZERO_REG) &
                 ((id_uses_r1 & (id_r1 == ex_rd)) | (id_uses_r2 & (id_r2 == ex_rd)));
  assign br    = mem_take_branch;
  assign fz    = dmem_busy;

  always_comb begin
    pc_en         = 1'b1;
    pc_sel_branch = 1'b0;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_en     = 1'b1;
    ex_mem_bubble = 1'b0;
    mem_wb_en     = 1'b1;
    state_nxt     = RUN;
    stall_ev      = 1'b0;
    flush_ev      = 1'b0;
    freeze_ev     = 1'b0;
    if (!reset) begin
      // Hold everything and squash all stage registers while in reset.
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_en     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if (fz) begin
      pc_en         = 1'b0;
      pc_sel_branch = br;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_en     = 1'b0;
      state_nxt     = FREEZE;
      freeze_ev     = 1'b1;
    end else if (br) begin
      // Squash wins over a pending load-use: the consumer is discarded anyway.
      pc_sel_branch = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      flush_ev      = 1'b1;
    end else if (lu_hz && state != STALL) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_bubble  = 1'b1;
      state_nxt     = STALL;
      stall_ev      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall_ev)  stall_cnt  <= stall_cnt + 1'b1;
      if (flush_ev)  flush_cnt  <= flush_cnt + 1'b1;
      if (freeze_ev) freeze_cnt <= freeze_cnt + 1'b1;
    end
  end
`else
  logic unused_ev;
  assign unused_ev  = stall_ev | flush_ev | freeze_ev;
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
  assign freeze_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected enable/strobe vectors queued with stimulus.
module tb_hazard_ctrl;
  localparam int CW = 4;

  // {pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, ex_mem_bubble, mem_wb_en}
  localparam logic [8:0] V_RUN   = 9'b1_0_1_0_1_0_1_0_1;
  localparam logic [8:0] V_RST   = 9'b0_0_0_1_0_1_0_1_0;
  localparam logic [8:0] V_STALL = 9'b0_0_0_0_1_1_1_0_1;
  localparam logic [8:0] V_BR    = 9'b1_1_1_1_1_1_1_1_1;
  localparam logic [8:0] V_FZBR  = 9'b0_1_0_0_0_0_0_0_0;
  localparam logic [8:0] V_FZ    = 9'b0_0_0_0_0_0_0_0_0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] id_r1 = '0, id_r2 = '0, ex_rd = '0;
  logic id_uses_r1 = 0, id_uses_r2 = 0, ex_mem_read = 0, ex_reg_write = 0;
  logic mem_take_branch = 0, dmem_busy = 0;
  logic pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
  logic ex_mem_en, ex_mem_bubble, mem_wb_en;
  logic [CW-1:0] stall_cnt, flush_cnt, freeze_cnt;

  hazard_ctrl #(.ZERO_REG(5'd31), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_r1(id_r1), .id_r2(id_r2), .id_uses_r1(id_uses_r1), .id_uses_r2(id_uses_r2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .mem_take_branch(mem_take_branch), .dmem_busy(dmem_busy),
    .pc_en(pc_en), .pc_sel_branch(pc_sel_branch), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
    .ex_mem_en(ex_mem_en), .ex_mem_bubble(ex_mem_bubble), .mem_wb_en(mem_wb_en),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  always #5 clk = ~clk;

  logic [8:0] obs;
  assign obs = {pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
                ex_mem_en, ex_mem_bubble, mem_wb_en};

  logic [8:0] exp_q[$];
  logic [8:0] e;
  int total = 0, bad = 0;
  int n_stall = 0, n_flush = 0, n_freeze = 0;

  function automatic logic [CW-1:0] ec(input int n);
`ifdef HAZARD_PERF_CNT_EN
    return CW'(n);
`else
    return '0;
`endif
  endfunction

  task automatic set_in(input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic mr,
                        input logic rw, input logic b, input logic busy);
    id_r1 = r1; id_r2 = r2; id_uses_r1 = u1; id_uses_r2 = u2; ex_rd = rd;
    ex_mem_read = mr; ex_reg_write = rw; mem_take_branch = b; dmem_busy = busy;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(V_RST);
    #3;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL reset_outputs: got %b want %b", obs, e); end
    total++;
    if ({stall_cnt, flush_cnt, freeze_cnt} !== '0) begin
      bad++; $display("FAIL reset_counters: got %h want 0", {stall_cnt, flush_cnt, freeze_cnt});
    end
    @(negedge clk); reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_load_use();
    set_in(3, 0, 1, 0, 3, 1, 1, 0, 0);
    exp_q.push_back(V_STALL); #2;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL lu_stall: got %b want %b", obs, e); end
    next_cycle(); n_stall++;
    exp_q.push_back(V_RUN); #2;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL lu_suppressed: got %b want %b", obs, e); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    total++;
    if (stall_cnt !== ec(n_stall)) begin
      bad++; $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, ec(n_stall));
    end
  endtask

  task automatic test_no_dep();
    // XZR destination, unused source, non-load and a real rs2 dependency
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin set_in(31, 0, 1, 0, 31, 1, 1, 0, 0); exp_q.push_back(V_RUN); end
        1: begin set_in(3, 0, 0, 0, 3, 1, 1, 0, 0);   exp_q.push_back(V_RUN); end
        2: begin set_in(7, 0, 1, 0, 7, 0, 1, 0, 0);   exp_q.push_back(V_RUN); end
        default: begin set_in(1, 9, 0, 1, 9, 1, 1, 0, 0); exp_q.push_back(V_STALL); end
      endcase
      #2;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL no_dep_case%0d: got %b want %b", i, obs, e); end
      if (i == 3) n_stall++;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
    end
  endtask

  task automatic test_branch_lu();
    set_in(3, 0, 1, 0, 3, 1, 1, 1, 0);
    exp_q.push_back(V_BR); #2;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL br_over_lu: got %b want %b", obs, e); end
    next_cycle(); n_flush++;
    // State must be RUN, so the same load-use now stalls.
    set_in(3, 0, 1, 0, 3, 1, 1, 0, 0);
    exp_q.push_back(V_STALL); #2;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL br_then_run: got %b want %b", obs, e); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle(); n_stall++;
    total++;
    if (flush_cnt !== ec(n_flush)) begin
      bad++; $display("FAIL br_flush_cnt: got %0d want %0d", flush_cnt, ec(n_flush));
    end
  endtask

  task automatic test_freeze();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
      exp_q.push_back(V_FZBR); #2;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL freeze_cyc%0d: got %b want %b", i, obs, e); end
      next_cycle(); n_freeze++;
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    exp_q.push_back(V_BR); #2;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL freeze_then_br: got %b want %b", obs, e); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle(); n_flush++;
    total++;
    if (freeze_cnt !== ec(n_freeze) || flush_cnt !== ec(n_flush)) begin
      bad++; $display("FAIL freeze_cnts: got fz=%0d fl=%0d want fz=%0d fl=%0d",
                      freeze_cnt, flush_cnt, ec(n_freeze), ec(n_flush));
    end
  endtask

  task automatic test_freeze_from_stall();
    // Freezing out of STALL loses that history: a still-present hazard stalls again.
    for (int i = 0; i < 4; i++) begin
      set_in(4, 0, 1, 0, 4, 1, 1, 0, i == 1);
      case (i)
        0: exp_q.push_back(V_STALL);
        1: exp_q.push_back(V_FZ);
        2: exp_q.push_back(V_STALL);
        default: exp_q.push_back(V_RUN);
      endcase
      #2;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL fz_stall_step%0d: got %b want %b", i, obs, e); end
      if (i == 0 || i == 2) n_stall++;
      if (i == 1) n_freeze++;
      if (i == 3) set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
    end
    total++;
    if (stall_cnt !== ec(n_stall)) begin
      bad++; $display("FAIL fz_stall_cnt: got %0d want %0d", stall_cnt, ec(n_stall));
    end
  endtask

  task automatic test_async_reset();
    set_in(5, 0, 1, 0, 5, 1, 1, 0, 0);
    next_cycle();
    #3;
    reset = 1'b0;
    n_stall = 0; n_flush = 0; n_freeze = 0;
    exp_q.push_back(V_RST); #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL async_rst_out: got %b want %b", obs, e); end
    total++;
    if ({stall_cnt, flush_cnt, freeze_cnt} !== '0) begin
      bad++; $display("FAIL async_rst_cnt: got %h want 0", {stall_cnt, flush_cnt, freeze_cnt});
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b1;
    next_cycle();
    exp_q.push_back(V_RUN); #2;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL async_rst_release: got %b want %b", obs, e); end
    // Fresh hazard must stall: no STALL state survives the reset.
    set_in(5, 0, 1, 0, 5, 1, 1, 0, 0);
    exp_q.push_back(V_STALL); #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL async_rst_fresh_lu: got %b want %b", obs, e); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle(); n_stall++;
    total++;
    if (stall_cnt !== ec(n_stall)) begin
      bad++; $display("FAIL async_rst_stall_cnt: got %0d want %0d", stall_cnt, ec(n_stall));
    end
  endtask

  task automatic test_back_to_back_wrap();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    n_stall = 0; n_flush = 0; n_freeze = 0;
    next_cycle();
    // Held hazard alternates stall / suppressed: 34 cycles give 17 stalls.
    set_in(2, 0, 1, 0, 2, 1, 1, 0, 0);
    for (int i = 0; i < 34; i++) begin
      exp_q.push_back((i % 2 == 0) ? V_STALL : V_RUN); #2;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL b2b_cyc%0d: got %b want %b", i, obs, e); end
      if (i % 2 == 0) n_stall++;
      next_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (stall_cnt !== ec(n_stall)) begin
      bad++; $display("FAIL wrap_stall_cnt: got %0d want %0d", stall_cnt, ec(n_stall));
    end
    total++;
    if (flush_cnt !== ec(n_flush) || freeze_cnt !== ec(n_freeze)) begin
      bad++; $display("FAIL wrap_other_cnts: got fl=%0d fz=%0d want 0 0", flush_cnt, freeze_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_dep();
    test_branch_lu();
    test_freeze();
    test_freeze_from_stall();
    test_async_reset();
    test_back_to_back_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
